// File: rtl/kbd_axil_pkg.sv
// kbd_axil_pkg: register map, response codes and FIFO entry type for the keyboard subordinate.
// The entry type gains a 16-bit timestamp when KBD_TIMESTAMP_EN is defined.
package kbd_axil_pkg;
  localparam logic [31:0] CTRL_OFF     = 32'h00;
  localparam logic [31:0] STATUS_OFF   = 32'h04;
  localparam logic [31:0] DATA_OFF     = 32'h08;
  localparam logic [31:0] SCRATCH_BASE = 32'h0C;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;
`ifdef KBD_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  code;
  } fifo_entry_t;
`else
  typedef struct packed {
    logic [7:0] code;
  } fifo_entry_t;
`endif
endpackage

// File: rtl/kbd_sync_fifo.sv
// kbd_sync_fifo: power-of-2 synchronous FIFO with flush and a drop strobe for pushes refused while full.
module kbd_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  // a pop frees the slot a same-cycle push needs when full; flush overrides both
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign drop_o  = push_i & ~do_push & ~flush_i;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(do_push);
      rptr_q  <= rptr_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/kbd_axil_fifo_subordinate.sv
// kbd_axil_fifo_subordinate: AXI4-Lite scancode FIFO with CTRL/STATUS/DATA, scratch bank and level irq.
// Define KBD_TIMESTAMP_EN to tag each entry with a 16-bit cycle stamp returned in DATA[31:16].
module kbd_axil_fifo_subordinate
  import kbd_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH         = 16,
  parameter int NUM_SCRATCH        = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [7:0]                      kbd_code,
  input  logic                            kbd_valid,
  output logic                            irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MAP_END = SCRATCH_BASE + 32'(4 * NUM_SCRATCH);
  logic [1:0] ctrl_q, bresp_q, rresp_q;
  logic ovf_q, ovf_d, bvalid_q, rvalid_q, irq_q;
  logic [31:0] rdata_q, rd_data, data_word, status_word, waddr, raddr;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic wr_acc, rd_acc, wr_ctrl, flush, ovf_clr, pop_req, popped, push, full, empty, drop;
  logic [CW-1:0] count;
  fifo_entry_t push_entry, pop_entry;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign wr_acc = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
  assign rd_acc = S_AXI_ARVALID & ~rvalid_q;
  assign S_AXI_AWREADY = wr_acc;
  assign S_AXI_WREADY  = wr_acc;
  assign S_AXI_ARREADY = rd_acc;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign irq           = irq_q;
  assign waddr = 32'({S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
  assign raddr = 32'({S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
  assign wr_ctrl = wr_acc & (waddr == CTRL_OFF) & S_AXI_WSTRB[0];
  assign flush   = wr_ctrl & S_AXI_WDATA[CTRL_FLUSH];
  assign ovf_clr = wr_acc & (waddr == STATUS_OFF) & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
  assign ovf_d   = drop | (ovf_q & ~ovf_clr);
  assign push    = kbd_valid & ctrl_q[CTRL_EN];
  assign pop_req = rd_acc & (raddr == DATA_OFF);
  assign popped  = pop_req & ~empty & ~flush;
`ifdef KBD_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) ts_q <= '0;
    else ts_q <= ts_q + 16'd1;
  assign push_entry = '{ts: ts_q, code: kbd_code};
  assign data_word  = popped ? {pop_entry.ts, 7'b0, 1'b1, pop_entry.code} : '0;
`else
  assign push_entry = '{code: kbd_code};
  assign data_word  = popped ? {16'b0, 7'b0, 1'b1, pop_entry.code} : '0;
`endif
  assign status_word = {16'b0, 8'(count), 5'b0, ovf_q, full, empty};
  kbd_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fifo_entry_t))) u_fifo (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .push_i (push),
    .pop_i  (pop_req),
    .flush_i(flush),
    .wdata_i(push_entry),
    .rdata_o(pop_entry),
    .full_o (full),
    .empty_o(empty),
    .count_o(count),
    .drop_o (drop)
  );
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_SCRATCH; k++)
      if (raddr == SCRATCH_BASE + 32'(4 * k)) rd_data = scratch_q[k];
    rd_data = (raddr == CTRL_OFF) ? {30'b0, ctrl_q} : (raddr == STATUS_OFF) ? status_word :
              (raddr == DATA_OFF) ? data_word : rd_data;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      for (int k = 0; k < NUM_SCRATCH; k++) scratch_q[k] <= '0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= ctrl_q[CTRL_IRQ_EN] & ~empty;
      if (wr_ctrl) ctrl_q <= {S_AXI_WDATA[CTRL_IRQ_EN], S_AXI_WDATA[CTRL_EN]};
      for (int k = 0; k < NUM_SCRATCH; k++)
        for (int b = 0; b < 4; b++)
          if (wr_acc && waddr == SCRATCH_BASE + 32'(4 * k) && S_AXI_WSTRB[b])
            scratch_q[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      if (wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (waddr < MAP_END) ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rresp_q  <= (raddr < MAP_END) ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_data;
      end else if (S_AXI_RREADY) rvalid_q <= 1'b0;
    end
endmodule

// File: tb/tb_kbd_axil_fifo_subordinate.sv
// tb_kbd_axil_fifo_subordinate: directed bench for the AXI4-Lite keyboard FIFO subordinate.
module tb_kbd_axil_fifo_subordinate;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [7:0] kbd_code = '0;
  logic kbd_valid = 1'b0;
  logic irq_at_acc;
  logic [31:0] d;
  logic [1:0] r;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  kbd_axil_fifo_subordinate dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] dat, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("aw_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    irq_at_acc = irq;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_timeout", 32'(n < 20), 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic read_finish(output logic [31:0] dat, output logic [1:0] resp);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("r_timeout", 32'(n < 20), 32'd1);
    dat = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ar_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    read_finish(dat, resp);
  endtask

  task automatic strobe(input logic [7:0] c);
    kbd_code = c; kbd_valid = 1'b1;
    @(posedge clk); #1;
    kbd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {awready, wready, arready}, 32'd0);
    chk("rst_valid", {bvalid, rvalid, irq}, 32'd0);
    chk("rst_resp", {bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h04, d, r);  chk("status_rst", d, 32'h1); chk("status_rst_resp", r, 2'b00);
    axi_read(6'h00, d, r);  chk("ctrl_rst", d, 32'h0);
    axi_write(6'h0C, 32'hA5A5A5A5, 4'b0011, r); chk("scr_wr_resp", r, 2'b00);
    axi_read(6'h0C, d, r);  chk("scr_strb", d, 32'h0000A5A5);
    strobe(8'h55);
    axi_read(6'h04, d, r);  chk("disabled_push", d, 32'h1);
    axi_write(6'h00, 32'h1, 4'hF, r);
    strobe(8'h1C); strobe(8'h32); strobe(8'h23);
    axi_read(6'h04, d, r);  chk("count3", d, 32'h0300);
    axi_read(6'h08, d, r);  chk("pop1", d, 32'h11C);
    axi_read(6'h08, d, r);  chk("pop2", d, 32'h132);
    axi_read(6'h08, d, r);  chk("pop3", d, 32'h123);
    axi_read(6'h08, d, r);  chk("pop_empty", d, 32'h0); chk("pop_empty_resp", r, 2'b00);
    axi_read(6'h04, d, r);  chk("drained", d, 32'h1);
    for (int i = 0; i < 17; i++) strobe(8'(8'h40 + i));
    axi_read(6'h04, d, r);  chk("overflow", d, 32'h1006);
    axi_write(6'h04, 32'h4, 4'hF, r);
    axi_read(6'h04, d, r);  chk("ovf_w1c", d, 32'h1002);
    axi_read(6'h08, d, r);  chk("ovf_first", d, 32'h140);
    strobe(8'h60);
    axi_read(6'h04, d, r);  chk("refull", d, 32'h1002);
    araddr = 6'h08; arvalid = 1'b1; kbd_code = 8'h77; kbd_valid = 1'b1;
    #1;
    chk("sim_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; kbd_valid = 1'b0;
    read_finish(d, r);      chk("sim_pop", d, 32'h141);
    axi_read(6'h04, d, r);  chk("sim_status", d, 32'h1002);
    for (int i = 0; i < 16; i++) begin
      axi_read(6'h08, d, r);
      chk("drain", d, (i < 14) ? 32'(32'h142 + i) : (i == 14) ? 32'h160 : 32'h177);
    end
    axi_read(6'h04, d, r);  chk("drain_empty", d, 32'h1);
    axi_write(6'h00, 32'h3, 4'hF, r);
    kbd_code = 8'h2A; kbd_valid = 1'b1;
    @(posedge clk); #1;
    kbd_valid = 1'b0;
    chk("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    strobe(8'h2B);
    axi_write(6'h00, 32'h7, 4'hF, r);
    chk("irq_at_flush", 32'(irq_at_acc), 32'd1);
    chk("irq_clear", 32'(irq), 32'd0);
    axi_read(6'h04, d, r);  chk("flushed", d, 32'h1);
    axi_read(6'h00, d, r);  chk("ctrl_selfclr", d, 32'h3);
    axi_read(6'h3C, d, r);  chk("err_rdata", d, 32'h0); chk("err_rresp", r, 2'b10);
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, r); chk("err_bresp", r, 2'b10);
    awaddr = 6'h10; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    @(posedge clk); #1;
    wdata = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_awready", 32'(awready), 32'd0);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bp_bdone", 32'(bvalid), 32'd0);
    axi_read(6'h10, d, r);  chk("bp_single", d, 32'h11111111);
    araddr = 6'h0C; arvalid = 1'b1;
    #1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rbp_rvalid", 32'(rvalid), 32'd1);
      chk("rbp_rdata", rdata, 32'h0000A5A5);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rbp_done", 32'(rvalid), 32'd0);
`ifdef KBD_TIMESTAMP_EN
    begin
      logic [31:0] d0;
      strobe(8'h11);
      repeat (9) @(posedge clk);
      #1;
      strobe(8'h22);
      axi_read(6'h08, d0, r);
      axi_read(6'h08, d, r);
      chk("ts_delta", 32'(d[31:16] - d0[31:16]), 32'd10);
      chk("ts_code", {d0[15:0], d[15:0]}, 32'h01110122);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
